mod_sha256: RTL and testbench

//  SHA-256 compression engine. It holds the working hash state H[0..7], loads

---
 rtl/mod_sha256_pkg.sv | 63 ++++++
 rtl/mod_sha256_round.sv | 29 ++
 rtl/mod_sha256.sv | 178 +++++++++++++++++
 tb/tb_mod_sha256.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mod_sha256_pkg.sv
// Shared definitions for the SHA-256 compression engine: opcodes, FSM states,
// the round-constant table and the SHA-256 bit-mixing functions.
package mod_sha256_pkg;

  localparam logic [7:0] OP_IDLE    = 8'd0;
  localparam logic [7:0] OP_RESET_H = 8'd10;
  localparam logic [7:0] OP_HASH_B0 = 8'd20;
  localparam logic [7:0] OP_HASH_B1 = 8'd21;

  localparam logic [7:0] MSG_BASE_B0 = 8'd0;
  localparam logic [7:0] MSG_BASE_B1 = 8'd16;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOADH  = 3'd1,
    ST_LOADM  = 3'd2,
    ST_ROUNDS = 3'd3,
    ST_FINAL  = 3'd4,
    ST_DONE   = 3'd5
  } state_e;

  localparam logic [31:0] K [0:63] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  // Choose: f where e is 1, g where e is 0.
  function automatic logic [31:0] sha_ch(input logic [31:0] e, input logic [31:0] f, input logic [31:0] g);
    return (e & f) ^ (~e & g);
  endfunction

  // Majority of the three inputs, bitwise.
  function automatic logic [31:0] sha_maj(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c);
    return (a & b) ^ (a & c) ^ (b & c);
  endfunction

  // Big sigma 0: rotr 2 ^ rotr 13 ^ rotr 22.
  function automatic logic [31:0] sha_bsig0(input logic [31:0] x);
    return {x[1:0], x[31:2]} ^ {x[12:0], x[31:13]} ^ {x[21:0], x[31:22]};
  endfunction

  // Big sigma 1: rotr 6 ^ rotr 11 ^ rotr 25.
  function automatic logic [31:0] sha_bsig1(input logic [31:0] x);
    return {x[5:0], x[31:6]} ^ {x[10:0], x[31:11]} ^ {x[24:0], x[31:25]};
  endfunction

  // Small sigma 0: rotr 7 ^ rotr 18 ^ shr 3.
  function automatic logic [31:0] sha_ssig0(input logic [31:0] x);
    return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ {3'b000, x[31:3]};
  endfunction

  // Small sigma 1: rotr 17 ^ rotr 19 ^ shr 10.
  function automatic logic [31:0] sha_ssig1(input logic [31:0] x);
    return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ {10'd0, x[31:10]};
  endfunction

endpackage

// File: rtl/mod_sha256_round.sv
// One combinational SHA-256 round. Working variables are packed with
// index 0 = a ... index 7 = h.
module sha256_round
  import mod_sha256_pkg::*;
(
  input  logic [7:0][31:0] work_i,
  input  logic [31:0]      k_i,
  input  logic [31:0]      w_i,
  output logic [7:0][31:0] work_o
);

  logic [31:0] t1;
  logic [31:0] t2;

  // Compute T1/T2 and shift the working variables down by one position.
  always_comb begin
    t1 = work_i[7] + sha_bsig1(work_i[4]) + sha_ch(work_i[4], work_i[5], work_i[6]) + k_i + w_i;
    t2 = sha_bsig0(work_i[0]) + sha_maj(work_i[0], work_i[1], work_i[2]);
    work_o[0] = t1 + t2;
    work_o[1] = work_i[0];
    work_o[2] = work_i[1];
    work_o[3] = work_i[2];
    work_o[4] = work_i[3] + t1;
    work_o[5] = work_i[4];
    work_o[6] = work_i[5];
    work_o[7] = work_i[6];
  end

endmodule

// File: rtl/mod_sha256.sv
// SHA-256 compression engine: loads H from the H/K memory, loads one 512-bit
// block from the message memory, runs 64 rounds and folds the result into H.
// A level-held OPERATION / RDY handshake frames every command.
module mod_sha256
  import mod_sha256_pkg::*;
(
  input  logic        CLK,
  input  logic        RST_N,
  input  logic [7:0]  OPERATION,
  output logic [7:0]  HA,
  input  logic [31:0] HD,
  output logic [7:0]  MA,
  input  logic [31:0] MD,
  output logic        RDY
);

  state_e           state_q, state_d;
  logic [5:0]       cnt_q, cnt_d;
  logic [7:0]       op_q, op_d;
  logic [7:0]       ha_q, ha_d;
  logic [7:0]       ma_q, ma_d;
  logic             rdy_q, rdy_d;

  // Digest state; kept under this exact name so benches can reach mut.H[i].
  logic [31:0]      H [0:7];
  logic [7:0][31:0] work_q;
  logic [7:0][31:0] round_out;
  logic [31:0]      w_q [0:15];
  logic [31:0]      w_new;
  logic             start_hash;

  assign start_hash = (OPERATION == OP_HASH_B0) || (OPERATION == OP_HASH_B1);
  assign w_new      = sha_ssig1(w_q[14]) + w_q[9] + sha_ssig0(w_q[1]) + w_q[0];

  assign HA  = ha_q;
  assign MA  = ma_q;
  assign RDY = rdy_q;

  sha256_round u_round (
    .work_i (work_q),
    .k_i    (K[cnt_q]),
    .w_i    (w_q[0]),
    .work_o (round_out)
  );

  // Next-state logic for the command FSM, counters, address and RDY registers.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    ha_d    = ha_q;
    ma_d    = ma_q;
    rdy_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        cnt_d = 6'd0;
        if (OPERATION == OP_RESET_H) begin
          op_d    = OPERATION;
          ha_d    = 8'd0;
          state_d = ST_LOADH;
        end else if (OPERATION == OP_HASH_B0) begin
          op_d    = OPERATION;
          ma_d    = MSG_BASE_B0;
          state_d = ST_LOADM;
        end else if (OPERATION == OP_HASH_B1) begin
          op_d    = OPERATION;
          ma_d    = MSG_BASE_B1;
          state_d = ST_LOADM;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_LOADH: begin
        if (cnt_q == 6'd7) begin
          cnt_d   = 6'd0;
          state_d = ST_DONE;
        end else begin
          cnt_d = cnt_q + 6'd1;
          ha_d  = ha_q + 8'd1;
        end
      end
      ST_LOADM: begin
        if (cnt_q == 6'd15) begin
          cnt_d   = 6'd0;
          state_d = ST_ROUNDS;
        end else begin
          cnt_d = cnt_q + 6'd1;
          ma_d  = ma_q + 8'd1;
        end
      end
      ST_ROUNDS: begin
        if (cnt_q == 6'd63) begin
          cnt_d   = 6'd0;
          state_d = ST_FINAL;
        end else begin
          cnt_d = cnt_q + 6'd1;
        end
      end
      ST_FINAL: begin
        state_d = ST_DONE;
      end
      ST_DONE: begin
        // RDY stays up only while the controller keeps the same command.
        if (OPERATION == op_q) begin
          rdy_d = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Control registers with asynchronous active-low reset.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= ST_IDLE;
      cnt_q   <= 6'd0;
      op_q    <= OP_IDLE;
      ha_q    <= 8'd0;
      ma_q    <= 8'd0;
      rdy_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      ha_q    <= ha_d;
      ma_q    <= ma_d;
      rdy_q   <= rdy_d;
    end
  end

  // Datapath: H array, working variables and the 16-word message window.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      work_q <= '0;
      for (int i = 0; i < 8; i++) begin
        H[i] <= 32'd0;
      end
      for (int i = 0; i < 16; i++) begin
        w_q[i] <= 32'd0;
      end
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start_hash) begin
            for (int i = 0; i < 8; i++) begin
              work_q[i] <= H[i];
            end
          end
        end
        ST_LOADH: begin
          H[cnt_q[2:0]] <= HD;
        end
        ST_LOADM: begin
          w_q[cnt_q[3:0]] <= MD;
        end
        ST_ROUNDS: begin
          work_q <= round_out;
          for (int i = 0; i < 15; i++) begin
            w_q[i] <= w_q[i+1];
          end
          w_q[15] <= w_new;
        end
        ST_FINAL: begin
          for (int i = 0; i < 8; i++) begin
            H[i] <= H[i] + work_q[i];
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mod_sha256.sv
// Self-checking bench for mod_sha256: table of known vectors, handshake and
// reset corner cases, and random blocks checked against a behavioural model.
module tb_mod_sha256;

  localparam logic [7:0] OP_IDLE    = 8'd0;
  localparam logic [7:0] OP_RESET_H = 8'd10;
  localparam logic [7:0] OP_HASH_B0 = 8'd20;
  localparam logic [7:0] OP_HASH_B1 = 8'd21;

  localparam logic [31:0] IV [8] = '{
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };

  localparam logic [31:0] TB_K [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  typedef struct packed {
    logic [7:0]   op;
    logic [31:0]  m0;
    logic [31:0]  m15;
    logic [255:0] dig;
  } vec_t;

  logic        CLK = 1'b0;
  logic        RST_N;
  logic [7:0]  OPERATION;
  logic [7:0]  HA;
  logic [31:0] HD;
  logic [7:0]  MA;
  logic [31:0] MD;
  logic        RDY;

  logic [31:0] hmem [256];
  logic [31:0] mmem [256];
  logic [31:0] model_h [8];
  logic [7:0]  exp_ha;
  logic [7:0]  exp_ma;
  int          n_tests = 0;
  int          n_fail  = 0;
  vec_t        tbl [4];

  assign HD = hmem[HA];
  assign MD = mmem[MA];

  mod_sha256 mut (
    .CLK       (CLK),
    .RST_N     (RST_N),
    .OPERATION (OPERATION),
    .HA        (HA),
    .HD        (HD),
    .MA        (MA),
    .MD        (MD),
    .RDY       (RDY)
  );

  always #5 CLK = ~CLK;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time exhausted, required completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h, required %08h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  // Textbook SHA-256 compression of mmem[base..base+15] into model_h.
  task automatic model_compress(input int base);
    logic [31:0] w [64];
    logic [31:0] v [8];
    logic [31:0] s0, s1, t1, t2, chv, majv;
    for (int t = 0; t < 16; t++) w[t] = mmem[base + t];
    for (int t = 16; t < 64; t++) begin
      s0 = rotr(w[t-15], 7) ^ rotr(w[t-15], 18) ^ (w[t-15] >> 3);
      s1 = rotr(w[t-2], 17) ^ rotr(w[t-2], 19) ^ (w[t-2] >> 10);
      w[t] = w[t-16] + s0 + w[t-7] + s1;
    end
    for (int i = 0; i < 8; i++) v[i] = model_h[i];
    for (int t = 0; t < 64; t++) begin
      s1   = rotr(v[4], 6) ^ rotr(v[4], 11) ^ rotr(v[4], 25);
      chv  = (v[4] & v[5]) ^ (~v[4] & v[6]);
      t1   = v[7] + s1 + chv + TB_K[t] + w[t];
      s0   = rotr(v[0], 2) ^ rotr(v[0], 13) ^ rotr(v[0], 22);
      majv = (v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]);
      t2   = s0 + majv;
      v[7] = v[6]; v[6] = v[5]; v[5] = v[4]; v[4] = v[3] + t1;
      v[3] = v[2]; v[2] = v[1]; v[1] = v[0]; v[0] = t1 + t2;
    end
    for (int i = 0; i < 8; i++) model_h[i] = model_h[i] + v[i];
  endtask

  task automatic check_state(input string name);
    for (int i = 0; i < 8; i++) check(name, mut.H[i], model_h[i]);
    check({name, "_ha"}, {24'd0, HA}, {24'd0, exp_ha});
    check({name, "_ma"}, {24'd0, MA}, {24'd0, exp_ma});
  endtask

  // Issue a command, watch the address sweep and the latency, update the model.
  task automatic run_op(input logic [7:0] op);
    int         cyc;
    int         n_addr;
    int         base;
    int         lat;
    bit         got;
    logic [7:0] addrs [$];
    base   = (op == OP_HASH_B1) ? 16 : 0;
    n_addr = (op == OP_RESET_H) ? 8 : 16;
    lat    = (op == OP_RESET_H) ? 9 : 82;
    OPERATION = op;
    cyc = 0;
    got = 1'b0;
    while (!got && cyc < 200) begin
      @(negedge CLK);
      cyc++;
      if (RDY) got = 1'b1;
      else addrs.push_back((op == OP_RESET_H) ? HA : MA);
    end
    check("rdy_seen", {31'd0, got}, 32'd1);
    check("latency", cyc - 1, lat);
    check("addr_count", {31'd0, addrs.size() >= n_addr}, 32'd1);
    for (int k = 0; k < n_addr && k < addrs.size(); k++)
      check("addr_sweep", {24'd0, addrs[k]}, base + k);
    if (op == OP_RESET_H) begin
      for (int i = 0; i < 8; i++) model_h[i] = hmem[i];
      exp_ha = 8'd7;
    end else begin
      model_compress(base);
      exp_ma = 8'(base + 15);
    end
  endtask

  // Hold the command a few cycles, then drop to idle and expect RDY to fall.
  task automatic release_op();
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      check("rdy_hold", {31'd0, RDY}, 32'd1);
    end
    OPERATION = OP_IDLE;
    @(negedge CLK);
    check("rdy_drop", {31'd0, RDY}, 32'd0);
    @(negedge CLK);
  endtask

  initial begin
    int base;
    logic [7:0] op;

    tbl[0] = '{op: OP_RESET_H, m0: 32'h0, m15: 32'h0,
               dig: {32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
                     32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19}};
    tbl[1] = '{op: OP_HASH_B0, m0: 32'h61626380, m15: 32'h00000018,
               dig: {32'hba7816bf, 32'h8f01cfea, 32'h414140de, 32'h5dae2223,
                     32'hb00361a3, 32'h96177a9c, 32'hb410ff61, 32'hf20015ad}};
    tbl[2] = tbl[0];
    tbl[3] = tbl[1];
    tbl[3].op = OP_HASH_B1;

    for (int i = 0; i < 256; i++) begin
      hmem[i] = $urandom;
      mmem[i] = 32'd0;
    end
    for (int i = 0; i < 8; i++) begin
      hmem[i]    = IV[i];
      model_h[i] = 32'd0;
    end
    exp_ha = 8'd0;
    exp_ma = 8'd0;
    OPERATION = OP_IDLE;
    RST_N = 1'b0;
    #12;
    check_state("reset");
    check("reset_rdy", {31'd0, RDY}, 32'd0);
    @(negedge CLK);
    RST_N = 1'b1;
    @(negedge CLK);

    // Known-answer vectors: IV load and the padded "abc" block at both bases.
    for (int v = 0; v < 4; v++) begin
      base = (tbl[v].op == OP_HASH_B1) ? 16 : 0;
      for (int i = 0; i < 256; i++) mmem[i] = 32'd0;
      mmem[base]      = tbl[v].m0;
      mmem[base + 15] = tbl[v].m15;
      run_op(tbl[v].op);
      for (int i = 0; i < 8; i++)
        check("tbl_digest", mut.H[i], tbl[v].dig[255 - 32*i -: 32]);
      check_state("tbl_model");
      release_op();
    end

    // Invalid opcode: nothing may move.
    OPERATION = 8'd55;
    for (int i = 0; i < 20; i++) begin
      @(negedge CLK);
      check("invalid_rdy", {31'd0, RDY}, 32'd0);
    end
    check_state("invalid_hold");
    OPERATION = OP_IDLE;
    @(negedge CLK);

    // Asynchronous reset in the middle of round 30 of a hash.
    for (int i = 0; i < 16; i++) mmem[i] = $urandom;
    OPERATION = OP_HASH_B0;
    for (int i = 0; i < 47; i++) @(negedge CLK);
    check("midhash_rdy", {31'd0, RDY}, 32'd0);
    #2;
    RST_N = 1'b0;
    #1;
    for (int i = 0; i < 8; i++) model_h[i] = 32'd0;
    exp_ha = 8'd0;
    exp_ma = 8'd0;
    check_state("abort");
    check("abort_rdy", {31'd0, RDY}, 32'd0);
    OPERATION = OP_IDLE;
    @(negedge CLK);
    RST_N = 1'b1;
    @(negedge CLK);
    run_op(OP_RESET_H);
    check_state("after_abort");
    release_op();

    // Random H values and random blocks against the model.
    for (int it = 0; it < 4; it++) begin
      for (int i = 0; i < 8; i++) hmem[i] = $urandom;
      run_op(OP_RESET_H);
      check_state("rand_load");
      release_op();
      for (int i = 0; i < 32; i++) mmem[i] = $urandom;
      op = ($urandom_range(0, 1) == 0) ? OP_HASH_B0 : OP_HASH_B1;
      run_op(op);
      check_state("rand_hash");
      release_op();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
